// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: one butterfly per cycle,
// per-stage read/twiddle addressing and a delay line that aligns write-back to results.
module fft_stage_sequencer #(
    parameter int LOG2N        = 10,
    parameter int BFLY_LATENCY = 3,
    parameter int RD_LATENCY   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic             o_bf_start,
    input  logic             i_bf_valid,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b,
    output logic             o_sync_err
);
    localparam int KW    = LOG2N - 1;
    localparam int SW    = $clog2(LOG2N);
    localparam int DEPTH = RD_LATENCY + BFLY_LATENCY;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } dl_entry_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [KW-1:0]   k_q, k_d;
    dl_entry_t       dl_q [DEPTH];
    dl_entry_t       dl_d [DEPTH];
    logic            sync_err_q, sync_err_d;

    logic             rd_en;
    logic             in_flight;
    logic [KW-1:0]    mask_k, pos_k, hi_k;
    logic [LOG2N-1:0] addr_a, addr_b, half;
    logic [SW-1:0]    tw_shift;
    logic [KW-1:0]    tw;

    // k splits into grp (bits >= s) and pos (bits < s); grp<<(s+1) is just the high part shifted by one.
    always_comb begin
        mask_k   = ~({KW{1'b1}} << stage_q);
        pos_k    = k_q & mask_k;
        hi_k     = k_q & ~mask_k;
        addr_a   = {hi_k, 1'b0} | {1'b0, pos_k};
        half     = LOG2N'(1) << stage_q;
        addr_b   = addr_a | half;
        tw_shift = SW'(LOG2N - 1) - stage_q;
        tw       = pos_k << tw_shift;
    end

    // Entries ahead of the tail; the stage may end while the tail still holds its last write.
    always_comb begin
        in_flight = 1'b0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            in_flight = in_flight | dl_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                k_d   = k_q + 1'b1;
                if (k_q == {KW{1'b1}}) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dl_d[0].valid = rd_en;
        dl_d[0].a     = rd_en ? addr_a : '0;
        dl_d[0].b     = rd_en ? addr_b : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        sync_err_d = dl_q[DEPTH-1].valid ^ i_bf_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            sync_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            sync_err_q <= sync_err_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_rd_en     = rd_en;
    assign o_rd_addr_a = rd_en ? addr_a : '0;
    assign o_rd_addr_b = rd_en ? addr_b : '0;
    assign o_tw_addr   = rd_en ? tw : '0;
    assign o_bf_start  = dl_q[RD_LATENCY-1].valid;
    assign o_wr_en     = dl_q[DEPTH-1].valid;
    assign o_wr_addr_a = dl_q[DEPTH-1].a;
    assign o_wr_addr_b = dl_q[DEPTH-1].b;
    assign o_sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=8: address tables per stage, write-back
// alignment, done/busy timing, mid-run reset, held start and sync-error detection.
module tb_fft_stage_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       o_busy, o_done, o_rd_en, o_bf_start, o_wr_en, o_sync_err;
    logic [2:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
    logic [1:0] o_tw_addr;
    logic       i_bf_valid;
    logic [2:0] bf_pipe;
    logic       kill;

    int n_checks = 0;
    int n_pass   = 0;

    int a_tab  [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int b_tab  [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int tw_tab [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    fft_stage_sequencer #(.LOG2N(3), .BFLY_LATENCY(3), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
        .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b), .o_tw_addr(o_tw_addr),
        .o_bf_start(o_bf_start), .i_bf_valid(i_bf_valid),
        .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b),
        .o_sync_err(o_sync_err)
    );

    always #5 clk = ~clk;

    // Butterfly stand-in: valid 3 cycles after start, optionally suppressed.
    always @(posedge clk) begin
        if (reset) bf_pipe <= '0;
        else       bf_pipe <= {bf_pipe[1:0], o_bf_start};
    end
    assign i_bf_valid = bf_pipe[2] & ~kill;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, o_busy, 0);
        check({tag, " done"}, o_done, 0);
        check({tag, " rd_en"}, o_rd_en, 0);
        check({tag, " rd_a"}, o_rd_addr_a, 0);
        check({tag, " rd_b"}, o_rd_addr_b, 0);
        check({tag, " tw"}, o_tw_addr, 0);
        check({tag, " bf_start"}, o_bf_start, 0);
        check({tag, " wr_en"}, o_wr_en, 0);
        check({tag, " wr_a"}, o_wr_addr_a, 0);
        check({tag, " wr_b"}, o_wr_addr_b, 0);
        check({tag, " sync_err"}, o_sync_err, 0);
    endtask

    // Expected outputs for cycle c of an undisturbed N=8 run (period 8, done at 25).
    task automatic check_cycle(input int c, input int kill_at);
        int  s, off;
        bit  live, rd, wr;
        string t;
        s    = (c - 1) / 8;
        off  = (c - 1) % 8;
        live = (c >= 1) && (c <= 24);
        rd   = live && (off < 4);
        wr   = live && (off >= 4);
        t    = $sformatf("c%0d", c);
        check({t, " rd_en"}, o_rd_en, rd);
        check({t, " rd_a"}, o_rd_addr_a, rd ? a_tab[s][off] : 0);
        check({t, " rd_b"}, o_rd_addr_b, rd ? b_tab[s][off] : 0);
        check({t, " tw"}, o_tw_addr, rd ? tw_tab[s][off] : 0);
        check({t, " bf_start"}, o_bf_start, live && off >= 1 && off <= 4);
        check({t, " wr_en"}, o_wr_en, wr);
        check({t, " wr_a"}, o_wr_addr_a, wr ? a_tab[s][off-4] : 0);
        check({t, " wr_b"}, o_wr_addr_b, wr ? b_tab[s][off-4] : 0);
        check({t, " busy"}, o_busy, c <= 25);
        check({t, " done"}, o_done, c == 25);
        check({t, " sync_err"}, o_sync_err, (kill_at > 0) && (c == kill_at + 1));
    endtask

    // Launch a transform; optionally reset at cycle reset_at, kill one valid at kill_at,
    // or hold start high to observe the automatic restart.
    task automatic run_xform(input int reset_at, input int kill_at, input bit hold);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) i_start = 1'b0;
            if (reset_at > 0 && c == reset_at + 1) begin
                check_all_zero($sformatf("rst c%0d", c));
                reset = 1'b0;
                return;
            end
            check_cycle(c, kill_at);
            kill  = (c == kill_at);
            reset = (c == reset_at);
            @(posedge clk);
        end
        if (hold) begin
            @(negedge clk);
            check("restart busy", o_busy, 1);
            check("restart rd_en", o_rd_en, 1);
            check("restart rd_a", o_rd_addr_a, 0);
            check("restart rd_b", o_rd_addr_b, 1);
            i_start = 1'b0;
            reset   = 1'b1;
            @(negedge clk);
            reset   = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_start = 1'b0;
        kill    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        i_start = 1'b1;
        @(negedge clk);
        check("start ignored in reset", o_busy, 0);
        i_start = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_xform(0, 0, 1'b0);
        run_xform(10, 0, 1'b0);
        run_xform(0, 0, 1'b0);
        run_xform(0, 5, 1'b0);
        run_xform(0, 0, 1'b1);

        @(negedge clk);
        check_all_zero("final idle");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
